// File: rtl/pll_reset_sequencer_pkg.sv
// PLL reset sequencer: shared state type, output bundle and default timing.
// Defaults assume a 50 MHz reference clock.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_e;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_STABLE_CYCLES       = 1024;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_SYNC_STAGES         = 2;

  typedef struct packed {
    logic pll_rst;
    logic sys_rst;
    logic ready;
    logic fault;
  } out_t;

  function automatic out_t outs_of(state_e s);
    out_t o;
    o.pll_rst = (s == RESET_PLL) || (s == FAULT);
    o.sys_rst = (s != RUN);
    o.ready   = (s == RUN);
    o.fault   = (s == FAULT);
    return o;
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side control/status bundle of the reset sequencer.
// master = sequencer, slave = PLL and downstream logic.
interface pll_reset_sequencer_if #(
  parameter int MAX_RETRIES = 3
);

  localparam int RW = $clog2(MAX_RETRIES + 1);

  logic          pll_locked;
  logic          force_relock;
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic          fault;
  logic          lock_lost;
  logic [RW-1:0] retry_count;

  modport master (
    input  pll_locked, force_relock,
    output pll_rst, sys_rst, ready,
    output fault, lock_lost, retry_count
  );

  modport slave (
    output pll_locked, force_relock,
    input  pll_rst, sys_rst, ready,
    input  fault, lock_lost, retry_count
  );

endinterface

// File: rtl/pll_reset_sequencer_sync.sv
// Multi-flop synchroniser for a single level signal.
// Synchronous reset clears every stage to 0.
module cdc_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL reset, qualifies lock and releases the system reset.
// Retries failed locks, latches a fault, re-sequences on lock loss.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input logic                   refclk,
  input logic                   rst,
  pll_reset_sequencer_if.master bus
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int CW = $clog2(max3(RST_PULSE_CYCLES,
    LOCK_TIMEOUT_CYCLES, STABLE_CYCLES) + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam bit            STB_ONE  = (STABLE_CYCLES == 1);
  // The lock sample that enters STABLE is the first of the window.
  localparam logic [CW-1:0] STB_LAST =
    CW'(STB_ONE ? 0 : STABLE_CYCLES - 2);
  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRIES);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] rc_q;
  out_t          out_q;
  logic          lost_q;
  logic          locked_s;

  cdc_bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(refclk),
    .rst_i(rst),
    .d_i  (bus.pll_locked),
    .q_o  (locked_s)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= RESET_PLL;
      cnt_q   <= '0;
      rc_q    <= '0;
      out_q   <= outs_of(RESET_PLL);
      lost_q  <= 1'b0;
    end else begin
      lost_q <= 1'b0;
      unique case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            out_q   <= outs_of(WAIT_LOCK);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            cnt_q <= '0;
            if (STB_ONE) begin
              state_q <= RUN;
              rc_q    <= '0;
              out_q   <= outs_of(RUN);
            end else begin
              state_q <= STABLE;
              out_q   <= outs_of(STABLE);
            end
          end else if (cnt_q == TO_LAST) begin
            cnt_q <= '0;
            if (rc_q == MAXR - 1'b1) begin
              state_q <= FAULT;
              rc_q    <= MAXR;
              out_q   <= outs_of(FAULT);
            end else begin
              state_q <= RESET_PLL;
              rc_q    <= rc_q + 1'b1;
              out_q   <= outs_of(RESET_PLL);
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            out_q   <= outs_of(WAIT_LOCK);
          end else if (cnt_q == STB_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            rc_q    <= '0;
            out_q   <= outs_of(RUN);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s || bus.force_relock) begin
            state_q <= RESET_PLL;
            cnt_q   <= '0;
            out_q   <= outs_of(RESET_PLL);
            lost_q  <= !locked_s;
          end
        end
        FAULT: begin
          if (bus.force_relock) begin
            state_q <= RESET_PLL;
            cnt_q   <= '0;
            rc_q    <= '0;
            out_q   <= outs_of(RESET_PLL);
          end
        end
        default: begin
          state_q <= RESET_PLL;
          cnt_q   <= '0;
          out_q   <= outs_of(RESET_PLL);
        end
      endcase
    end
  end

  assign bus.pll_rst     = out_q.pll_rst;
  assign bus.sys_rst     = out_q.sys_rst;
  assign bus.ready       = out_q.ready;
  assign bus.fault       = out_q.fault;
  assign bus.lock_lost   = lost_q;
  assign bus.retry_count = rc_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: vector table, corner sequences,
// and random lock/relock traffic against a phase-level model.
module tb_pll_reset_sequencer;

  localparam int RP = 4;
  localparam int TO = 100;
  localparam int SC = 20;
  localparam int MR = 3;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pll_reset_sequencer_if #(.MAX_RETRIES(MR)) bus ();

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_TIMEOUT_CYCLES(TO),
    .STABLE_CYCLES      (SC),
    .MAX_RETRIES        (MR),
    .SYNC_STAGES        (SS)
  ) dut (
    .refclk(clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: phase, time in phase, lock run length, failed attempts.
  localparam int P_PULSE = 0;
  localparam int P_WAIT  = 1;
  localparam int P_QUAL  = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAULT = 4;

  int ph    = P_PULSE;
  int t     = 0;
  int locks = 0;
  int m_rc  = 0;
  bit m_ll  = 1'b0;
  bit hist[SS];

  function automatic void check(string nm, logic [7:0] got,
                                logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endfunction

  function automatic void checki(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endfunction

  task automatic model_edge(input bit r, input bit l, input bit f);
    bit ls;
    if (r) begin
      ph = P_PULSE; t = 0; locks = 0; m_rc = 0; m_ll = 1'b0;
      for (int i = 0; i < SS; i++) hist[i] = 1'b0;
      return;
    end
    ls = hist[SS-1];
    for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = l;
    m_ll = 1'b0;
    case (ph)
      P_PULSE: begin
        t++;
        if (t == RP) begin ph = P_WAIT; t = 0; end
      end
      P_WAIT: begin
        if (ls) begin
          locks = 1;
          if (locks >= SC) begin ph = P_RUN; m_rc = 0; end
          else ph = P_QUAL;
        end else begin
          t++;
          if (t == TO) begin
            m_rc++;
            t = 0;
            ph = (m_rc == MR) ? P_FAULT : P_PULSE;
          end
        end
      end
      P_QUAL: begin
        if (!ls) begin ph = P_WAIT; t = 0; end
        else begin
          locks++;
          if (locks >= SC) begin ph = P_RUN; m_rc = 0; end
        end
      end
      P_RUN: begin
        if (!ls) begin m_ll = 1'b1; ph = P_PULSE; t = 0; end
        else if (f) begin ph = P_PULSE; t = 0; end
      end
      P_FAULT: begin
        if (f) begin ph = P_PULSE; t = 0; m_rc = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic check_model();
    check("m_pll_rst", 8'(bus.pll_rst),
          8'(ph == P_PULSE || ph == P_FAULT));
    check("m_sys_rst", 8'(bus.sys_rst), 8'(ph != P_RUN));
    check("m_ready", 8'(bus.ready), 8'(ph == P_RUN));
    check("m_fault", 8'(bus.fault), 8'(ph == P_FAULT));
    check("m_lock_lost", 8'(bus.lock_lost), 8'(m_ll));
    check("m_retry", 8'(bus.retry_count), 8'(m_rc));
  endtask

  task automatic step(input bit r, input bit l, input bit f);
    @(negedge clk);
    rst = r;
    bus.pll_locked = l;
    bus.force_relock = f;
    @(posedge clk);
    model_edge(r, l, f);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_ready(input bit l, input int lim,
                            output int k);
    k = -1;
    for (int i = 1; i <= lim; i++) begin
      step(1'b0, l, 1'b0);
      if (bus.ready === 1'b1) begin k = i; break; end
    end
  endtask

  typedef struct {
    int n;
    bit r, l, f;
    bit pr, sr, rd, ft, ll;
    int rc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int k, k1, k2, kf;
    bit ll_seen;
    bus.pll_locked = 1'b0;
    bus.force_relock = 1'b0;
    for (int i = 0; i < SS; i++) hist[i] = 1'b0;

    // n, r, l, f,  pll_rst, sys_rst, ready, fault, lock_lost, rc
    tbl[0]  = '{2,  1, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{3,  0, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1,  0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{26, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{21, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{1,  0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{5,  0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{1,  0, 1, 1, 1, 1, 0, 0, 0, 0};
    tbl[8]  = '{4,  0, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[9]  = '{1,  0, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{18, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{1,  0, 1, 0, 0, 0, 1, 0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < tbl[i].n; j++)
        step(tbl[i].r, tbl[i].l, tbl[i].f);
      check($sformatf("tbl%0d_pll_rst", i), 8'(bus.pll_rst),
            8'(tbl[i].pr));
      check($sformatf("tbl%0d_sys_rst", i), 8'(bus.sys_rst),
            8'(tbl[i].sr));
      check($sformatf("tbl%0d_ready", i), 8'(bus.ready),
            8'(tbl[i].rd));
      check($sformatf("tbl%0d_fault", i), 8'(bus.fault),
            8'(tbl[i].ft));
      check($sformatf("tbl%0d_lock_lost", i), 8'(bus.lock_lost),
            8'(tbl[i].ll));
      check($sformatf("tbl%0d_retry", i), 8'(bus.retry_count),
            8'(tbl[i].rc));
    end

    // Glitch during qualification
    do_reset();
    ll_seen = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      ll_seen |= bus.lock_lost;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      ll_seen |= bus.lock_lost;
    end
    check("glitch_not_ready", 8'(bus.ready), 8'd0);
    wait_ready(1'b1, 200, k);
    checki("glitch_release", k, 22);
    check("glitch_no_lost", 8'(ll_seen | bus.lock_lost), 8'd0);
    check("glitch_retry", 8'(bus.retry_count), 8'd0);

    // Never locks: three timeouts then fault
    do_reset();
    k1 = -1; k2 = -1; kf = -1;
    for (int i = 1; i <= 400; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (k1 < 0 && bus.retry_count == 2'd1) k1 = i;
      if (k2 < 0 && bus.retry_count == 2'd2) k2 = i;
      if (bus.fault === 1'b1) begin kf = i; break; end
    end
    checki("retry1_at", k1, 104);
    checki("retry2_at", k2, 208);
    checki("fault_at", kf, 312);
    check("fault_retry", 8'(bus.retry_count), 8'd3);
    check("fault_pll_rst", 8'(bus.pll_rst), 8'd1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    check("fault_held", 8'(bus.fault), 8'd1);
    step(1'b0, 1'b1, 1'b1);
    check("fault_clr", 8'(bus.fault), 8'd0);
    check("fault_clr_retry", 8'(bus.retry_count), 8'd0);
    check("fault_clr_pll_rst", 8'(bus.pll_rst), 8'd1);

    // Lock loss in RUN
    do_reset();
    wait_ready(1'b1, 100, k);
    checki("bringup2", k, 24);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    k = -1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.sys_rst === 1'b1) begin k = i; break; end
    end
    checki("loss_latency", k, 3);
    check("loss_pulse", 8'(bus.lock_lost), 8'd1);
    check("loss_ready", 8'(bus.ready), 8'd0);
    step(1'b0, 1'b0, 1'b0);
    check("loss_pulse_end", 8'(bus.lock_lost), 8'd0);
    check("loss_pll_rst", 8'(bus.pll_rst), 8'd1);
    wait_ready(1'b1, 300, k);
    checki("relock_done", int'(k > 0), 1);

    // Lock drop and force_relock on the same edge
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("both_pulse", 8'(bus.lock_lost), 8'd1);

    // force_relock ignored in WAIT_LOCK
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("wait_force_ign", 8'(bus.pll_rst), 8'd0);
    k = -1;
    for (int i = 7; i <= 200; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.retry_count == 2'd1) begin k = i; break; end
    end
    checki("wait_timeout_kept", k, 104);

    // Reset in the middle of qualification
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("mid_rst_pll_rst", 8'(bus.pll_rst), 8'd1);
    check("mid_rst_sys_rst", 8'(bus.sys_rst), 8'd1);
    check("mid_rst_ready", 8'(bus.ready), 8'd0);
    wait_ready(1'b1, 100, k);
    checki("mid_rst_restart", k, 24);

    // Random lock/unlock/relock traffic
    do_reset();
    begin
      bit lvl;
      bit fr;
      bit rr;
      int hold;
      lvl = 1'b0;
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
        if (hold == 0) begin
          lvl = ($urandom_range(0, 9) < 7);
          hold = $urandom_range(1, 80);
        end
        hold--;
        fr = ($urandom_range(0, 99) == 0);
        rr = ($urandom_range(0, 999) == 0);
        step(rr, lvl, fr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
